// File: rtl/adder_rr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_rr_pkg
// Description : Shared constants, state encodings and the round-robin
//               arbitration helper for the adder_rr_sched block.
// Revision    : 1.0 - initial release
// ============================================================================
package adder_rr_pkg;

    // Default datapath width of the shared add/subtract unit
    localparam int ADDER_WIDTH = 16;

    // Operation select encodings
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Requester identifiers
    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    // Output register occupancy
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Two-way round-robin: a lone requester always wins, on a tie the
    // requester that did not win last time goes first. Returns {g1, g0}.
    function automatic logic [1:0] rr_grant(
        input logic v0,
        input logic v1,
        input logic last
    );
        logic g0;
        logic g1;
        g0 = v0 && (!v1 || (last == REQ_ID1));
        g1 = v1 && (!v0 || (last == REQ_ID0));
        return {g1, g0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_sub_core.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_core
// Description : Combinational two's-complement add/subtract with carry-out
//               (no-borrow on subtract) and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module add_sub_core
    import adder_rr_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_full;

    // Subtract is A + ~B + 1; the carry-in doubles as the op bit
    always_comb begin
        w_b_eff = (op == OP_SUB) ? ~b : b;
        w_full  = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, op};
        sum     = w_full[WIDTH-1:0];
        cout    = w_full[WIDTH];
        ovf     = (a[WIDTH-1] == w_b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule
`default_nettype wire

// File: rtl/adder_rr_sched.sv
`default_nettype none
// ============================================================================
// Module      : adder_rr_sched
// Description : Round-robin scheduler sharing one add/subtract unit between
//               two valid/ready requesters; single registered result slot
//               with backpressure and a saturating overflow counter.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_rr_sched
    import adder_rr_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_op,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf,

    output logic [CNT_W-1:0] ovf_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    out_state_e       r_state_q,   w_state_d;
    logic             r_last_q,    w_last_d;
    logic             r_id_q,      w_id_d;
    logic [WIDTH-1:0] r_sum_q,     w_sum_d;
    logic             r_cout_q,    w_cout_d;
    logic             r_ovf_q,     w_ovf_d;
    logic [CNT_W-1:0] r_cnt_q,     w_cnt_d;

    logic             w_can_accept;
    logic [1:0]       w_grant;
    logic             w_issue;
    logic             w_sel;
    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic             w_op;
    logic [WIDTH-1:0] w_core_sum;
    logic             w_core_cout;
    logic             w_core_ovf;

    // Arbitrate only when the result slot is free or being drained; reset blocks all handshakes
    always_comb begin
        w_can_accept = !rst && ((r_state_q == ST_EMPTY) || rsp_ready);
        w_grant      = rr_grant(req0_valid, req1_valid, r_last_q) & {2{w_can_accept}};
        w_issue      = |w_grant;
        w_sel        = w_grant[1] ? REQ_ID1 : REQ_ID0;
        w_op_a       = w_grant[1] ? req1_a  : req0_a;
        w_op_b       = w_grant[1] ? req1_b  : req0_b;
        w_op         = w_grant[1] ? req1_op : req0_op;
    end

    add_sub_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a    (w_op_a),
        .b    (w_op_b),
        .op   (w_op),
        .sum  (w_core_sum),
        .cout (w_core_cout),
        .ovf  (w_core_ovf)
    );

    // Next-state: an issue overwrites the slot (covers drain+issue in one edge), otherwise a drain empties it
    always_comb begin
        w_state_d = r_state_q;
        w_last_d  = r_last_q;
        w_id_d    = r_id_q;
        w_sum_d   = r_sum_q;
        w_cout_d  = r_cout_q;
        w_ovf_d   = r_ovf_q;
        w_cnt_d   = r_cnt_q;
        if (w_issue) begin
            w_state_d = ST_FULL;
            w_last_d  = w_sel;
            w_id_d    = w_sel;
            w_sum_d   = w_core_sum;
            w_cout_d  = w_core_cout;
            w_ovf_d   = w_core_ovf;
            if (w_core_ovf && (r_cnt_q != C_CNT_MAX)) begin
                w_cnt_d = r_cnt_q + 1'b1;
            end
        end else if ((r_state_q == ST_FULL) && rsp_ready) begin
            w_state_d = ST_EMPTY;
        end
    end

    // Result slot, round-robin pointer and overflow counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_EMPTY;
            r_last_q  <= REQ_ID1;
            r_id_q    <= REQ_ID0;
            r_sum_q   <= '0;
            r_cout_q  <= 1'b0;
            r_ovf_q   <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_last_q  <= w_last_d;
            r_id_q    <= w_id_d;
            r_sum_q   <= w_sum_d;
            r_cout_q  <= w_cout_d;
            r_ovf_q   <= w_ovf_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign rsp_valid  = (r_state_q == ST_FULL);
    assign rsp_id     = r_id_q;
    assign rsp_sum    = r_sum_q;
    assign rsp_cout   = r_cout_q;
    assign rsp_ovf    = r_ovf_q;
    assign ovf_cnt    = r_cnt_q;

endmodule
`default_nettype wire
